// File: rtl/key_report_tx.sv
// key_report_tx: debounces a key_down vector and frames it into UART byte
// packets (header, payload LSB-first, XOR checksum) using a send/done handshake.
// Packets are sent when the debounced state changes (mode=0) or back-to-back
// (mode=1), with an enforced idle gap after each packet.
module key_report_tx #(
  parameter int         N_KEYS        = 40,
  parameter logic [7:0] HDR_BYTE      = 8'hA5,
  parameter int         STABLE_CYCLES = 4,
  parameter int         GAP_CYCLES    = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_down,
  input  logic              mode,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_done,
  output logic              busy,
  output logic [15:0]       pkt_count,
  output logic              overrun
);

  localparam int NB   = (N_KEYS + 7) / 8;
  localparam int IDXW = $clog2(NB + 2);
  localparam int CNTW = $clog2(STABLE_CYCLES + 1);
  localparam int GAPW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NB + 1);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(STABLE_CYCLES);
  localparam logic [CNTW-1:0] CNT_HIT  = CNTW'(STABLE_CYCLES - 1);
  localparam logic [GAPW-1:0] GAP_LAST = GAPW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [N_KEYS-1:0]   raw_q, stable_q, last_sent_q, snap_q;
  logic [N_KEYS-1:0]   last_sent_d;
  logic [CNTW-1:0]     cnt_q;
  logic                pending_q, overrun_q;
  logic [IDXW-1:0]     idx_q;
  logic [7:0]          csum_q;
  logic [GAPW-1:0]     gap_q;
  logic [15:0]         pkt_q;

  logic                stable_upd, stable_chg, is_payload;
  logic [8*NB-1:0]     snap_pad;
  logic [7:0]          pay_bytes [NB];
  logic [7:0]          pay_sel, cur_byte;

  // The raw vector has held long enough when the counter hits its last step.
  assign stable_upd  = (key_down == raw_q) && (cnt_q == CNT_HIT);
  assign stable_chg  = stable_upd && (raw_q != stable_q);
  // LOAD records the snapshot as sent; pending compares against that new value.
  assign last_sent_d = (state_q == S_LOAD) ? stable_q : last_sent_q;

  // Debounce, change tracking and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q       <= '0;
      cnt_q       <= '0;
      stable_q    <= '0;
      last_sent_q <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      raw_q <= key_down;
      if (key_down != raw_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
      if (stable_upd) begin
        stable_q <= raw_q;
      end
      last_sent_q <= last_sent_d;
      if (stable_upd && (raw_q != last_sent_d)) begin
        pending_q <= 1'b1;
      end else if (state_q == S_LOAD) begin
        pending_q <= 1'b0;
      end
      // In LOAD the pending value is being captured, so it is not lost.
      if (stable_chg && pending_q && (state_q != S_IDLE) && (state_q != S_LOAD)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Zero-pad the snapshot to whole bytes and split it into payload bytes.
  assign snap_pad = (8*NB)'(snap_q);

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bytes
      assign pay_bytes[gi] = snap_pad[8*gi +: 8];
    end
  endgenerate

  // Select the payload byte addressed by idx (idx 1..NB map to bytes 0..NB-1).
  always_comb begin
    pay_sel = 8'h00;
    for (int k = 0; k < NB; k++) begin
      if (idx_q == IDXW'(k + 1)) begin
        pay_sel = pay_bytes[k];
      end
    end
  end

  assign is_payload = (idx_q != '0) && (idx_q != IDX_LAST);
  assign cur_byte   = (idx_q == '0)      ? HDR_BYTE :
                      (idx_q == IDX_LAST) ? csum_q   : pay_sel;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; tx_done only matters in WAIT, mode only in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (mode || pending_q) state_d = S_LOAD;
      S_LOAD: state_d = S_SEND;
      S_SEND: state_d = S_WAIT;
      S_WAIT: if (tx_done) state_d = (idx_q == IDX_LAST) ? S_GAP : S_SEND;
      S_GAP:  if (gap_q == GAP_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: send pulse, busy flag and the byte on the wire.
  always_comb begin
    tx_send = (state_q == S_SEND);
    busy    = (state_q != S_IDLE);
    tx_data = ((state_q == S_SEND) || (state_q == S_WAIT)) ? cur_byte : 8'h00;
  end

  // Packet datapath: snapshot, byte index, running checksum, gap timer, count.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
      idx_q  <= '0;
      csum_q <= 8'h00;
      gap_q  <= '0;
      pkt_q  <= 16'h0000;
    end else begin
      case (state_q)
        S_LOAD: begin
          snap_q <= stable_q;
          idx_q  <= '0;
          csum_q <= 8'h00;
        end
        S_SEND: begin
          if (is_payload) csum_q <= csum_q ^ pay_sel;
        end
        S_WAIT: begin
          if (tx_done) begin
            if (idx_q == IDX_LAST) begin
              pkt_q <= pkt_q + 16'd1;
              gap_q <= '0;
            end else begin
              idx_q <= idx_q + IDXW'(1);
            end
          end
        end
        S_GAP: gap_q <= gap_q + GAPW'(1);
        default: ;
      endcase
    end
  end

  assign pkt_count = pkt_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_key_report_tx.sv
// Directed testbench for key_report_tx with a simple UART done-pulse model.
module tb_key_report_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] key_down;
  logic        mode;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_done = 1'b0;
  logic        busy;
  logic [15:0] pkt_count;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] byte_q [$];
  int         stamp_q [$];
  logic [2:0] dly = 3'd0;

  key_report_tx #(
    .N_KEYS(40), .HDR_BYTE(8'hA5), .STABLE_CYCLES(4), .GAP_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .key_down(key_down), .mode(mode),
    .tx_data(tx_data), .tx_send(tx_send), .tx_done(tx_done),
    .busy(busy), .pkt_count(pkt_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: one-cycle tx_done pulse 5 cycles after the tx_send cycle.
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (tx_send) begin
      dly <= 3'd5;
    end else if (dly != 3'd0) begin
      if (dly == 3'd2) tx_done <= 1'b1;
      dly <= dly - 3'd1;
    end
  end

  // Byte monitor, one line per transmitted byte.
  always @(negedge clk) begin
    if (tx_send) begin
      byte_q.push_back(tx_data);
      stamp_q.push_back(cyc);
      $display("tx byte %02h at cycle %0d", tx_data, cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int t = 0;
    while (byte_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t = 0;
    while (busy && t < budget) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_idle"}, busy, 1'b0);
  endtask

  // exp holds the 7 packet bytes, first byte in the top bits.
  task automatic check_packet(input string tag, input logic [55:0] exp,
                              output int first_c, output int last_c);
    logic [7:0] b;
    int         c;
    int         c0;
    first_c = 0;
    last_c  = 0;
    c0      = 0;
    wait_bytes(7, 400);
    if (byte_q.size() < 7) begin
      check_eq({tag, "_timeout"}, byte_q.size(), 7);
      return;
    end
    for (int i = 0; i < 7; i++) begin
      b = byte_q.pop_front();
      c = stamp_q.pop_front();
      if (i == 0) begin
        first_c = c;
        c0      = c;
      end
      if (i == 1) check_eq({tag, "_spacing"}, c - c0, 6);
      if (i == 6) last_c = c;
      check_eq($sformatf("%s_b%0d", tag, i), b, exp[55-8*i -: 8]);
    end
    $display("packet %s received, expected %014h", tag, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f1, l1, f2, l2, f3, l3;
    rst = 1'b1;
    mode = 1'b0;
    key_down = 40'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_send", tx_send, 1'b0);
    check_eq("rst_data", tx_data, 8'h00);
    check_eq("rst_pkt", pkt_count, 16'h0);
    check_eq("rst_ovr", overrun, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 1: quiet input produces nothing.
    repeat (100) @(negedge clk);
    check_eq("t1_bytes", byte_q.size(), 0);
    check_eq("t1_busy", busy, 1'b0);
    check_eq("t1_pkt", pkt_count, 16'h0);

    // 2: single key held -> one packet, then silence.
    key_down = 40'h00_0000_0001;
    check_packet("t2", 56'hA5_01_00_00_00_00_01, f1, l1);
    wait_idle("t2", 100);
    check_eq("t2_pkt", pkt_count, 16'd1);
    repeat (100) @(negedge clk);
    check_eq("t2_quiet", byte_q.size(), 0);
    check_eq("t2_pkt_hold", pkt_count, 16'd1);

    // 3: 3-cycle glitch is rejected.
    key_down = 40'h80_0000_0000;
    repeat (3) @(negedge clk);
    key_down = 40'h00_0000_0001;
    repeat (50) @(negedge clk);
    check_eq("t3_bytes", byte_q.size(), 0);
    check_eq("t3_pkt", pkt_count, 16'd1);
    check_eq("t3_ovr", overrun, 1'b0);

    // 4: two accepted changes during a packet -> overrun, latest sent next.
    key_down = 40'h0;
    wait_bytes(2, 100);
    key_down = 40'h01_0000_0000;
    repeat (10) @(negedge clk);
    key_down = 40'h02_0000_0000;
    repeat (8) @(negedge clk);
    check_eq("t4_midpkt_busy", busy, 1'b1);
    check_eq("t4_ovr", overrun, 1'b1);
    check_packet("t4a", 56'hA5_00_00_00_00_00_00, f1, l1);
    check_packet("t4b", 56'hA5_00_00_00_00_02_02, f1, l1);
    wait_idle("t4", 100);
    check_eq("t4_pkt", pkt_count, 16'd3);

    // 5: change packet, then periodic packets in mode 1.
    // Checksum: 9A^78^56^34^12 = 92.
    key_down = 40'h12_3456_789A;
    check_packet("t5a", 56'hA5_9A_78_56_34_12_92, f1, l1);
    wait_idle("t5a", 100);
    check_eq("t5a_pkt", pkt_count, 16'd4);
    mode = 1'b1;
    check_packet("t5b", 56'hA5_9A_78_56_34_12_92, f2, l2);
    check_packet("t5c", 56'hA5_9A_78_56_34_12_92, f3, l3);
    mode = 1'b0;
    check_eq("t5_pkt_inc", pkt_count, 16'd5);
    // csum send -> done (5) -> next SEND (1) -> GAP (8) -> IDLE -> LOAD -> SEND.
    check_eq("t5_gap", f3 - l2, 16);
    wait_idle("t5c", 100);
    check_eq("t5_pkt", pkt_count, 16'd6);
    repeat (30) @(negedge clk);
    check_eq("t5_stopped", byte_q.size(), 0);

    // 6: reset during WAIT of byte 3 aborts the packet.
    key_down = 40'h00_0000_0055;
    wait_bytes(4, 200);
    repeat (2) @(negedge clk);
    check_eq("t6_pre_busy", busy, 1'b1);
    rst = 1'b1;
    key_down = 40'h0;
    @(posedge clk);
    #1;
    check_eq("t6_busy", busy, 1'b0);
    check_eq("t6_send", tx_send, 1'b0);
    check_eq("t6_data", tx_data, 8'h00);
    check_eq("t6_pkt", pkt_count, 16'h0);
    check_eq("t6_ovr", overrun, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    byte_q.delete();
    stamp_q.delete();
    repeat (30) @(negedge clk);
    check_eq("t6_quiet", byte_q.size(), 0);
    check_eq("t6_quiet_busy", busy, 1'b0);
    // Checksum: 55^AA^00^00^C3 = 3C.
    key_down = 40'hC3_0000_AA55;
    check_packet("t6", 56'hA5_55_AA_00_00_C3_3C, f1, l1);
    wait_idle("t6", 100);
    check_eq("t6_pkt_after", pkt_count, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
